stack_op_sequencer: RTL and testbench
=====================================

# stack_op_sequencer

Initiator-side controller for the 8-bit hardware stack: accepts one stack-machine instruction at a time over a valid/ready handshake and expands it into the push/pop/top-of-stack strobe sequence the stack expects. It performs the ALU step itself, tracks stack depth to reject underflow and overflow, and sits between instruction decode and the stack in the stack-based processor datapath.

## Interface
- `DEPTH`, 32: stack capacity in entries.
- `INIT_DEPTH`, 2: number of entries the stack holds out of reset.
- `DW`, 8: data width; fixed at 8 for this design.

Ports:
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  instruction offered.
- `op_ready`  out  1  high only in IDLE.
- `opcode`  in  3  000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 DUP, 111 reserved.
- `imm`  in  8  PUSH operand.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`; the instruction was rejected.
- `result`  out  8  last ALU result, or the value removed by POP/DUP.
- `depth`  out  $clog2(DEPTH+1)  current entry count.
- `s_push`, `s_pop`, `s_tos`  out  1 each  stack command strobes.
- `s_din`  out  8  push data.
- `s_dout`  in  8  stack read data.
- `c_flag`, `z_flag`  out  1 each  carry/borrow and zero flags (see Configuration).

## Operation
- **Handshake.** A transfer occurs on the edge where `op_valid & op_ready`. `opcode` and `imm` are latched on that edge and must not be relied on afterwards. The accept edge is called T.
- **Pre-check at accept.** Operands needed: PUSH 0, POP/NOT 1, DUP 1, binary 2. Net change in depth: PUSH +1, DUP +1, POP −1, binary −1, NOT 0.
  - The instruction is rejected if `depth` is below the operand count, if depth plus the net change exceeds `DEPTH`, or if the opcode is 111.
  - A rejected instruction goes straight to DONE with `err=1` and issues no strobes.
- **State machine.** IDLE → (POP1 → CAP1) → (POP2 → CAP2) → PUSH → DONE → IDLE. Unused states are skipped per opcode.
  - DUP uses TOS in place of POP1.
  - POP skips the PUSH state.
  - PUSH goes IDLE → PUSH → DONE.
- **Stack read protocol.** The stack presents read data on `s_dout` during the cycle after `s_pop` or `s_tos` was asserted. The sequencer samples it at the end of that cycle (the CAP states).
  - The first sample is A (the top of stack); the second is B (the entry below it).
- **ALU.**
  - ADD: B+A.
  - SUB: B−A.
  - AND: B&A.
  - NOT: ~A.
  - Arithmetic is modulo 256.
- **Push data.** `s_din` carries the result (or `imm` for PUSH, or A for DUP) in the PUSH state.
- **`result`.** Loaded with the ALU result, with `imm` for PUSH, or with A for POP/DUP. It holds its value otherwise.
- **`depth`.** Increments in any cycle with `s_push` and decrements in any cycle with `s_pop`.
- **Strobe exclusivity.** At most one of `s_push`, `s_pop`, `s_tos` is high in any cycle. Each is asserted for exactly one cycle per state.
- **Reset values.** `op_ready=0` during reset and 1 in the first IDLE cycle after it. All strobes are 0. `done=0`, `err=0`, `result=0`, `s_din=0`, `c_flag=0`, `z_flag=0`. `depth=INIT_DEPTH`.
- **Reset mid-instruction.** The instruction is abandoned immediately: the state returns to IDLE and strobes go low on the reset edge. The stack is reset by the same `rst`.

## Timing
- `done` (and `err`) is high in the DONE cycle. `op_ready` rises the cycle after DONE.
- Latencies from accept T to the `done` cycle:
  - PUSH: T+2, with `s_push` at T+1.
  - POP: T+3, with `s_pop` at T+1 and `result` valid at T+3.
  - NOT and DUP: T+4, with the strobe at T+1 and `s_push` at T+3.
  - Binary ops: T+5, with `s_pop` at T+1 and T+2, A captured at the end of T+2, B captured at the end of T+3, and `s_push` at T+4.
  - Rejected instruction: T+1.
- Throughput is one instruction per (latency+1) cycles; there is no overlap between instructions.

## Configuration
- **`STACK_SEQ_FLAGS_EN` defined:**
  - On ADD, `c_flag` is the 9th bit of the sum.
  - On SUB, `c_flag` is the borrow, i.e. B<A.
  - On ADD, SUB, AND and NOT, `z_flag` is set when the result is 0.
  - Flags update in the PUSH state, are unchanged by other opcodes and by rejects, and reset to 0.
- **Undefined:** `c_flag` and `z_flag` are tied to 0 and no flag logic is built.

## Test plan
- After reset with `INIT_DEPTH=2`, the stack holds 0x15 below 0x3F (0x3F on top).
  - ADD: `s_pop` at T+1 and T+2, push of 0x54 at T+4, `done` at T+5.
  - `depth` 2→1 and `result=0x54`. With flags enabled, c=0 and z=0.
- Same initial state, SUB: pushes 0x15−0x3F = 0xD6. With flags enabled, c=1 and z=0.
- PUSH 0xAA then POP:
  - PUSH: `s_din=0xAA` at T+1 and `depth` 3.
  - POP: `result=0xAA` with `done` at T+3 and `depth` back to 2.
- Depth 1, ADD offered: `done=1`, `err=1` at T+1. No strobes, `depth` unchanged, `op_ready` high at T+2.
- Fill to `depth=DEPTH`, then DUP: rejected with `err`. Separately, opcode 111 is also rejected with `err`.
- Assert `rst` at T+2 of an ADD:
  - All strobes are 0 on the next cycle, `depth=INIT_DEPTH`, and `op_ready=1` one cycle after `rst` falls.
  - No spurious `done` is produced.

Source files
------------

// File: rtl/stack_op_sequencer.sv
// -----------------------------------------------------------------------------
// stack_op_sequencer
//
// Initiator-side controller for the 8-bit hardware stack. It accepts one
// stack-machine instruction at a time over a valid/ready handshake and expands
// it into the push/pop/top-of-stack strobe sequence the stack expects. The ALU
// step is done here, and stack depth is tracked so that underflow, overflow and
// the reserved opcode are rejected before any strobe is issued.
//
// Optional feature macro: STACK_SEQ_FLAGS_EN
//   defined   : c_flag / z_flag are built and updated by ADD, SUB, AND, NOT.
//   undefined : c_flag / z_flag are tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (also resets the stack)
//   op_valid  in   instruction offered
//   op_ready  out  high only while IDLE and able to accept
//   opcode    in   000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 NOT,
//                  110 DUP, 111 reserved
//   imm       in   PUSH operand
//   done      out  one-cycle completion pulse
//   err       out  qualifies done: instruction was rejected
//   result    out  last ALU result, PUSH immediate, or value removed by POP/DUP
//   depth     out  current stack entry count
//   s_push    out  stack push strobe
//   s_pop     out  stack pop strobe
//   s_tos     out  stack top-of-stack read strobe
//   s_din     out  stack push data
//   s_dout    in   stack read data (valid the cycle after s_pop / s_tos)
//   c_flag    out  carry / borrow flag
//   z_flag    out  zero flag
// -----------------------------------------------------------------------------
module stack_op_sequencer #(
  parameter int DEPTH      = 32,
  parameter int INIT_DEPTH = 2,
  parameter int DW         = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [2:0]                   opcode,
  input  logic [DW-1:0]                imm,
  output logic                         done,
  output logic                         err,
  output logic [DW-1:0]                result,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         s_push,
  output logic                         s_pop,
  output logic                         s_tos,
  output logic [DW-1:0]                s_din,
  input  logic [DW-1:0]                s_dout,
  output logic                         c_flag,
  output logic                         z_flag
);

  localparam int DPW = $clog2(DEPTH+1);
  localparam logic [DPW:0] DEPTH_W = (DPW+1)'(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  // CAP1 also carries the second pop of binary ops, so A is captured in the
  // same cycle that B is being requested.
  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_CAP1,
    S_CAP2,
    S_PUSH,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   alu_res;
  logic [DPW:0]    need_w;
  logic [DPW:0]    depth_w;
  logic            grow_w;
  logic            reject_w;
  logic            binary_q;

  // x is the value arriving on s_dout (A for unary ops, B for binary ops),
  // y is the captured A. POP and DUP just pass x through.
  function automatic logic [DW-1:0] alu_f(input logic [2:0] op,
                                          input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    case (op)
      OP_ADD:  alu_f = x + y;
      OP_SUB:  alu_f = x - y;
      OP_AND:  alu_f = x & y;
      OP_NOT:  alu_f = ~x;
      default: alu_f = x;
    endcase
  endfunction

  assign alu_res  = alu_f(op_q, s_dout, a_q);
  assign binary_q = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);

  // Operand count and whether the op grows the stack, checked at accept.
  always_comb begin
    need_w  = '0;
    grow_w  = 1'b0;
    depth_w = {1'b0, depth};
    case (opcode)
      OP_PUSH:        grow_w = 1'b1;
      OP_POP, OP_NOT: need_w = (DPW+1)'(1);
      OP_DUP: begin
        need_w = (DPW+1)'(1);
        grow_w = 1'b1;
      end
      default:        need_w = (DPW+1)'(2);
    endcase
    reject_w = (opcode == OP_RSV) || (depth_w < need_w) ||
               (grow_w && (depth_w >= DEPTH_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_PUSH;
      op_ready <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      s_push   <= 1'b0;
      s_pop    <= 1'b0;
      s_tos    <= 1'b0;
      result   <= '0;
      s_din    <= '0;
      depth    <= DPW'(INIT_DEPTH);
    end else begin
      s_push <= 1'b0;
      s_pop  <= 1'b0;
      s_tos  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      depth  <= depth + DPW'(s_push) - DPW'(s_pop);
      case (state_q)
        // IDLE: accept and pre-check
        S_IDLE: begin
          op_ready <= 1'b1;
          if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            op_q     <= opcode;
            if (reject_w) begin
              done    <= 1'b1;
              err     <= 1'b1;
              state_q <= S_DONE;
            end else if (opcode == OP_PUSH) begin
              s_push  <= 1'b1;
              s_din   <= imm;
              result  <= imm;
              state_q <= S_PUSH;
            end else if (opcode == OP_DUP) begin
              s_tos   <= 1'b1;
              state_q <= S_POP1;
            end else begin
              s_pop   <= 1'b1;
              state_q <= S_POP1;
            end
          end
        end
        // POP1: first strobe in flight; binary ops request B next
        S_POP1: begin
          s_pop   <= binary_q;
          state_q <= S_CAP1;
        end
        // CAP1: A is on s_dout
        S_CAP1: begin
          a_q <= s_dout;
          if (binary_q) begin
            state_q <= S_CAP2;
          end else if (op_q == OP_POP) begin
            result  <= alu_res;
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            result  <= alu_res;
            s_din   <= alu_res;
            s_push  <= 1'b1;
            state_q <= S_PUSH;
          end
        end
        // CAP2: B is on s_dout, binary result formed
        S_CAP2: begin
          result  <= alu_res;
          s_din   <= alu_res;
          s_push  <= 1'b1;
          state_q <= S_PUSH;
        end
        // PUSH: write-back strobe in flight
        S_PUSH: begin
          done    <= 1'b1;
          state_q <= S_DONE;
        end
        // DONE: completion pulse, ready returns next cycle
        default: begin
          op_ready <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef STACK_SEQ_FLAGS_EN
  logic c_q;
  logic z_q;
  logic flag_upd;

  // Flags are loaded together with the pushed result, so they are visible
  // from the PUSH cycle onward.
  assign flag_upd = (state_q == S_CAP2) ||
                    ((state_q == S_CAP1) && (op_q == OP_NOT));

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else if (flag_upd) begin
      z_q <= (alu_res == '0);
      // A wrapped sum is smaller than either addend; borrow is simply B < A.
      if (op_q == OP_ADD) c_q <= (alu_res < s_dout);
      if (op_q == OP_SUB) c_q <= (s_dout < a_q);
    end
  end

  assign c_flag = c_q;
  assign z_flag = z_q;
`else
  assign c_flag = 1'b0;
  assign z_flag = 1'b0;
`endif

endmodule

// File: tb/tb_stack_op_sequencer.sv
module tb_stack_op_sequencer;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

`ifdef STACK_SEQ_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [7:0] imm = 8'h00;
  logic       op_ready, done, err, s_push, s_pop, s_tos, c_flag, z_flag;
  logic [7:0] result, s_din;
  logic [7:0] s_dout;
  logic [5:0] depth;
  logic [2:0] stb;

  int checks = 0;
  int errors = 0;

  assign stb = {s_push, s_pop, s_tos};

  always #5 clk = ~clk;

  stack_op_sequencer #(.DEPTH(32), .INIT_DEPTH(2), .DW(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .imm(imm), .done(done), .err(err), .result(result),
    .depth(depth), .s_push(s_push), .s_pop(s_pop), .s_tos(s_tos),
    .s_din(s_din), .s_dout(s_dout), .c_flag(c_flag), .z_flag(z_flag)
  );

  // Behavioural stack: read data appears the cycle after s_pop / s_tos.
  logic [7:0] mem [0:63];
  int         sp;
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 8'h15;
      mem[1] <= 8'h3F;
      sp     <= 2;
      s_dout <= 8'h00;
    end else if (s_pop && sp > 0) begin
      s_dout <= mem[sp-1];
      sp     <= sp - 1;
    end else if (s_tos && sp > 0) begin
      s_dout <= mem[sp-1];
    end else if (s_push && sp < 64) begin
      mem[sp] <= s_din;
      sp      <= sp + 1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_valid = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Returns in cycle T+1 (one cycle after the accept edge).
  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    int n = 0;
    while (op_ready !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    if (op_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_wait op_ready=%b expected 1", op_ready);
    end
    op_valid = 1'b1;
    opcode = op;
    imm = d;
    step(1);
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++; if ({op_ready, stb, done, err} !== 6'b0) begin errors++; $display("FAIL rst_ctrl got %b expected 000000", {op_ready, stb, done, err}); end
    checks++; if ({result, s_din} !== 16'h0000) begin errors++; $display("FAIL rst_data got %h expected 0000", {result, s_din}); end
    checks++; if (depth !== 6'd2) begin errors++; $display("FAIL rst_depth got %0d expected 2", depth); end
    checks++; if ({c_flag, z_flag} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b expected 00", {c_flag, z_flag}); end
    rst = 1'b0;
    step(1);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b expected 1", op_ready); end
  endtask

  task automatic test_add();
    do_reset();
    issue(OP_ADD, 8'h00);
    checks++; if (stb !== 3'b010) begin errors++; $display("FAIL add_t1_stb got %b expected 010", stb); end
    step(1);
    checks++; if (stb !== 3'b010) begin errors++; $display("FAIL add_t2_stb got %b expected 010", stb); end
    step(1);
    checks++; if ({stb, done} !== 4'b0000) begin errors++; $display("FAIL add_t3_idle got %b expected 0000", {stb, done}); end
    step(1);
    checks++; if ({stb, s_din} !== {3'b100, 8'h54}) begin errors++; $display("FAIL add_t4_push got %b/%h expected 100/54", stb, s_din); end
    step(1);
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL add_t5_done got %b expected 10", {done, err}); end
    checks++; if (result !== 8'h54) begin errors++; $display("FAIL add_result got %h expected 54", result); end
    checks++; if (depth !== 6'd1) begin errors++; $display("FAIL add_depth got %0d expected 1", depth); end
    checks++; if ({c_flag, z_flag} !== 2'b00) begin errors++; $display("FAIL add_flags got %b expected 00", {c_flag, z_flag}); end
    step(1);
    checks++; if ({op_ready, done} !== 2'b10) begin errors++; $display("FAIL add_t6_ready got %b expected 10", {op_ready, done}); end
  endtask

  task automatic test_sub();
    do_reset();
    issue(OP_SUB, 8'h00);
    step(3);
    checks++; if ({stb, s_din} !== {3'b100, 8'hD6}) begin errors++; $display("FAIL sub_t4_push got %b/%h expected 100/d6", stb, s_din); end
    step(1);
    checks++; if ({done, err, result} !== {2'b10, 8'hD6}) begin errors++; $display("FAIL sub_done got %b/%h expected 10/d6", {done, err}, result); end
    checks++; if ({c_flag, z_flag} !== {FL, 1'b0}) begin errors++; $display("FAIL sub_flags got %b expected %b0", {c_flag, z_flag}, FL); end
  endtask

  task automatic test_push_pop();
    do_reset();
    issue(OP_PUSH, 8'hAA);
    checks++; if ({stb, s_din} !== {3'b100, 8'hAA}) begin errors++; $display("FAIL push_t1 got %b/%h expected 100/aa", stb, s_din); end
    step(1);
    checks++; if ({done, err, depth} !== {2'b10, 6'd3}) begin errors++; $display("FAIL push_t2 got %b/%0d expected 10/3", {done, err}, depth); end
    issue(OP_POP, 8'h00);
    checks++; if (stb !== 3'b010) begin errors++; $display("FAIL pop_t1_stb got %b expected 010", stb); end
    step(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pop_t2_done got %b expected 0", done); end
    step(1);
    checks++; if ({done, err, result} !== {2'b10, 8'hAA}) begin errors++; $display("FAIL pop_t3 got %b/%h expected 10/aa", {done, err}, result); end
    checks++; if (depth !== 6'd2) begin errors++; $display("FAIL pop_depth got %0d expected 2", depth); end
  endtask

  task automatic test_unary_and();
    do_reset();
    issue(OP_NOT, 8'h00);
    checks++; if (stb !== 3'b010) begin errors++; $display("FAIL not_t1_stb got %b expected 010", stb); end
    step(2);
    checks++; if ({stb, s_din} !== {3'b100, 8'hC0}) begin errors++; $display("FAIL not_t3_push got %b/%h expected 100/c0", stb, s_din); end
    step(1);
    checks++; if ({done, err, result, depth} !== {2'b10, 8'hC0, 6'd2}) begin errors++; $display("FAIL not_t4 got %b/%h/%0d expected 10/c0/2", {done, err}, result, depth); end
    issue(OP_DUP, 8'h00);
    checks++; if (stb !== 3'b001) begin errors++; $display("FAIL dup_t1_stb got %b expected 001", stb); end
    step(2);
    checks++; if ({stb, s_din} !== {3'b100, 8'hC0}) begin errors++; $display("FAIL dup_t3_push got %b/%h expected 100/c0", stb, s_din); end
    step(1);
    checks++; if ({done, err, result, depth} !== {2'b10, 8'hC0, 6'd3}) begin errors++; $display("FAIL dup_t4 got %b/%h/%0d expected 10/c0/3", {done, err}, result, depth); end
    issue(OP_PUSH, 8'h3F);
    step(1);
    issue(OP_AND, 8'h00);
    step(3);
    checks++; if ({stb, s_din} !== {3'b100, 8'h00}) begin errors++; $display("FAIL and_t4_push got %b/%h expected 100/00", stb, s_din); end
    step(1);
    checks++; if ({done, result, depth} !== {1'b1, 8'h00, 6'd3}) begin errors++; $display("FAIL and_t5 got %b/%h/%0d expected 1/00/3", done, result, depth); end
    checks++; if ({c_flag, z_flag} !== {1'b0, FL}) begin errors++; $display("FAIL and_flags got %b expected 0%b", {c_flag, z_flag}, FL); end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(OP_POP, 8'h00);
    step(2);
    checks++; if ({result, depth} !== {8'h3F, 6'd1}) begin errors++; $display("FAIL uf_pop got %h/%0d expected 3f/1", result, depth); end
    issue(OP_ADD, 8'h00);
    checks++; if ({done, err, stb} !== 5'b11000) begin errors++; $display("FAIL uf_t1 got %b expected 11000", {done, err, stb}); end
    checks++; if (depth !== 6'd1) begin errors++; $display("FAIL uf_depth got %0d expected 1", depth); end
    step(1);
    checks++; if ({op_ready, done, stb} !== 5'b10000) begin errors++; $display("FAIL uf_t2 got %b expected 10000", {op_ready, done, stb}); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      issue(OP_PUSH, 8'(i));
      step(1);
    end
    checks++; if (depth !== 6'd32) begin errors++; $display("FAIL of_fill got %0d expected 32", depth); end
    issue(OP_DUP, 8'h00);
    checks++; if ({done, err, stb, depth} !== {5'b11000, 6'd32}) begin errors++; $display("FAIL of_dup got %b/%0d expected 11000/32", {done, err, stb}, depth); end
    issue(OP_PUSH, 8'h77);
    checks++; if ({done, err, stb} !== 5'b11000) begin errors++; $display("FAIL of_push got %b expected 11000", {done, err, stb}); end
    issue(OP_POP, 8'h00);
    step(2);
    checks++; if ({done, err, result, depth} !== {2'b10, 8'h1D, 6'd31}) begin errors++; $display("FAIL of_pop got %b/%h/%0d expected 10/1d/31", {done, err}, result, depth); end
    do_reset();
    issue(OP_RSV, 8'h00);
    checks++; if ({done, err, stb, depth} !== {5'b11000, 6'd2}) begin errors++; $display("FAIL rsv got %b/%0d expected 11000/2", {done, err, stb}, depth); end
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    do_reset();
    issue(OP_ADD, 8'h00);
    step(1);
    rst = 1'b1;
    step(1);
    checks++; if ({stb, done, op_ready} !== 5'b00000) begin errors++; $display("FAIL rmid_t3 got %b expected 00000", {stb, done, op_ready}); end
    checks++; if (depth !== 6'd2) begin errors++; $display("FAIL rmid_depth got %0d expected 2", depth); end
    rst = 1'b0;
    step(1);
    checks++; if ({op_ready, done} !== 2'b10) begin errors++; $display("FAIL rmid_ready got %b expected 10", {op_ready, done}); end
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0) spurious++;
      step(1);
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL rmid_spurious got %0d expected 0", spurious); end
    issue(OP_ADD, 8'h00);
    step(4);
    checks++; if ({done, err, result, depth} !== {2'b10, 8'h54, 6'd1}) begin errors++; $display("FAIL rmid_readd got %b/%h/%0d expected 10/54/1", {done, err}, result, depth); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_push_pop();
    test_unary_and();
    test_underflow();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
